alu_mc: RTL

- Parametrised multi-cycle ALU, next generation of the single-cycle datapath ALU.
- Adds EOR, ADC, iterative unsigned MUL (2·WIDTH-bit product) and iterative UDIV (quotient and remainder) to the ADD, SUB, AND and ORR set.
- Uses a valid/ready/done handshake.
- Sits in the execute stage. The controller stalls on in_ready=0 and writes back on done.

---
 rtl/alu_mc.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR/EOR/ADC plus iterative
// unsigned shift-add MUL and restoring UDIV behind a valid/ready/done handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       ALUFlags,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, opa_q, opb_q;
  logic             dz_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [3:0]       flags_q;
  logic             done_q;

  logic             accept, iterative, last_step;
  logic [WIDTH-1:0] b_eff, sc_res;
  logic             c_eff, sc_c, sc_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] fin_hi, fin_lo;
  logic [3:0]       fin_flags;

  assign accept    = in_valid & in_ready;
  assign iterative = (ALUControl[2:1] == 2'b11);
  assign last_step = (cnt_q == CW'(1));

  // Shared adder for ADD/SUB/ADC; SUB is a + ~b + 1
  always_comb begin
    b_eff  = (ALUControl == 3'b001) ? ~b : b;
    c_eff  = (ALUControl == 3'b001) | ((ALUControl == 3'b101) & cin);
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    sc_res = sum[WIDTH-1:0];
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (ALUControl)
      3'b000, 3'b001, 3'b101: begin
        sc_c = sum[WIDTH];
        sc_v = ~(a[WIDTH-1] ^ b_eff[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      3'b010:  sc_res = a & b;
      3'b011:  sc_res = a | b;
      3'b100:  sc_res = a ^ b;
      default: sc_res = sum[WIDTH-1:0];
    endcase
  end

  // One iteration step; hi_q is partial product / remainder, lo_q is multiplier / quotient
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_diff = div_sh[WIDTH-1:0] - opb_q;
    div_hi   = div_ge ? div_diff : div_sh[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    fin_lo    = div_lo;
    fin_hi    = div_hi;
    fin_flags = 4'b0000;
    if (state_q == S_MUL) begin
      fin_lo = mul_lo;
      fin_hi = mul_hi;
    end else if (dz_q) begin
      fin_lo = '0;
      fin_hi = opa_q;
    end
    fin_flags = dz_q && (state_q == S_DIV) ? 4'b0101
                                           : {fin_lo[WIDTH-1], (fin_lo == '0), 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && iterative) state_d = ALUControl[0] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      dz_q        <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= 4'b0000;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hi_q  <= '0;
        lo_q  <= a;
        opa_q <= a;
        opb_q <= b;
        dz_q  <= (b == '0);
        if (iterative) begin
          cnt_q <= CW'(WIDTH);
        end else begin
          result_q    <= sc_res;
          result_hi_q <= '0;
          flags_q     <= {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
          done_q      <= 1'b1;
        end
      end else if (state_q != S_IDLE) begin
        if (state_q == S_MUL) begin
          hi_q <= mul_hi;
          lo_q <= mul_lo;
        end else begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        if (last_step) begin
          result_q    <= fin_lo;
          result_hi_q <= fin_hi;
          flags_q     <= fin_flags;
          done_q      <= 1'b1;
        end
      end
    end
  end

  assign Result   = result_q;
  assign ResultHi = result_hi_q;
  assign ALUFlags = flags_q;
  assign done     = done_q;

endmodule
